timer_display_driver: RTL and testbench

// - Consumer end of the road controller's countdown interface (timer[7:0], en).
// - Converts the binary timer value to BCD with a sequential double-dabble FSM.
// - Drives a 3-digit multiplexed common-anode 7-segment display, with leading-zero blanking.
// - Blanks the display while en is low. Sits between the road controller and the board display pins.

---
 rtl/timer_display_driver_if.sv | 31 +++
 rtl/timer_display_driver.sv | 183 ++++++++++++++++++
 tb/tb_timer_display_driver.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/timer_display_driver_if.sv
// Countdown/display bundle between the road controller, the display driver and the board pins.
// Latency: none (plain wires).
// Backpressure: none; the driver samples timer/en on every clock.
interface timer_display_driver_if;
    logic [7:0]  timer;
    logic        en;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic [11:0] bcd;
    logic        bcd_valid;

    // Producer side: road controller drives timer/en, observes display outputs
    modport master (
        output timer,
        output en,
        input  seg,
        input  an,
        input  bcd,
        input  bcd_valid
    );

    // Consumer side: the display driver
    modport slave (
        input  timer,
        input  en,
        output seg,
        output an,
        output bcd,
        output bcd_valid
    );
endinterface

// File: rtl/timer_display_driver.sv
// Binary countdown -> BCD (sequential double-dabble) -> 3-digit multiplexed 7-seg with leading-zero blanking.
// Latency: bcd_valid 10 clocks after timer is presented (1 capture + 8 shift + 1 done); seg/an 1 clock after index change.
// Backpressure: none; a new value is taken only when idle, so mid-conversion changes are picked up on return to IDLE.
module timer_display_driver #(
    parameter int REFRESH_DIV    = 24000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    timer_display_driver_if.slave  dsp
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int         CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    // Conversion state
    logic [1:0]       state_q,       state_d;
    logic [7:0]       last_q,        last_d;
    logic             have_q,        have_d;
    logic [7:0]       sr_q,          sr_d;
    logic [11:0]      scratch_q,     scratch_d;
    logic [2:0]       bit_cnt_q,     bit_cnt_d;
    logic [11:0]      bcd_q,         bcd_d;
    logic             bcd_valid_q,   bcd_valid_d;

    // Scan state
    logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]       digit_idx_q,   digit_idx_d;
    logic [6:0]       seg_q,         seg_d;
    logic [2:0]       an_q,          an_d;

    logic [11:0]      adj;

    // Active-high segment pattern for one decimal digit; out-of-range nibbles stay dark
    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p ^ {7{SEG_ACTIVE_LOW}};
    endfunction

    // Double-dabble correction: bump every nibble >= 5 by 3 before the shift
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < 3; i++) begin
            if (scratch_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM: capture a new/changed value, shift 8 times, publish result
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        have_d      = have_q;
        sr_d        = sr_q;
        scratch_d   = scratch_q;
        bit_cnt_d   = bit_cnt_q;
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dsp.en && (!have_q || (dsp.timer != last_q))) begin
                    last_d    = dsp.timer;
                    sr_d      = dsp.timer;
                    scratch_d = 12'h000;
                    bit_cnt_d = 3'd0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                scratch_d = {adj[10:0], sr_q[7]};
                sr_d      = {sr_q[6:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d       = scratch_q;
                bcd_valid_d = 1'b1;
                have_d      = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Digit scan timing: free-running slot counter, index steps ones->tens->hundreds
    always_comb begin
        refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
        digit_idx_d   = digit_idx_q;
        if (refresh_cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt_d = '0;
            digit_idx_d   = (digit_idx_q == 2'd2) ? 2'd0 : digit_idx_q + 2'd1;
        end
    end

    // Output mux with leading-zero blanking; the ones digit is always lit when enabled
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = 3'b111;
        if (dsp.en && have_q) begin
            case (digit_idx_q)
                2'd0: begin
                    an_d  = 3'b110;
                    seg_d = seg_pattern(bcd_q[3:0]);
                end
                2'd1: begin
                    if ((bcd_q[11:8] != 4'd0) || (bcd_q[7:4] != 4'd0)) begin
                        an_d  = 3'b101;
                        seg_d = seg_pattern(bcd_q[7:4]);
                    end
                end
                2'd2: begin
                    if (bcd_q[11:8] != 4'd0) begin
                        an_d  = 3'b011;
                        seg_d = seg_pattern(bcd_q[11:8]);
                    end
                end
                default: begin
                    an_d  = 3'b111;
                    seg_d = SEG_OFF;
                end
            endcase
        end
    end

    // State registers; reset aborts any conversion in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            last_q        <= 8'd0;
            have_q        <= 1'b0;
            sr_q          <= 8'd0;
            scratch_q     <= 12'h000;
            bit_cnt_q     <= 3'd0;
            bcd_q         <= 12'h000;
            bcd_valid_q   <= 1'b0;
            refresh_cnt_q <= '0;
            digit_idx_q   <= 2'd0;
            seg_q         <= SEG_OFF;
            an_q          <= 3'b111;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            have_q        <= have_d;
            sr_q          <= sr_d;
            scratch_q     <= scratch_d;
            bit_cnt_q     <= bit_cnt_d;
            bcd_q         <= bcd_d;
            bcd_valid_q   <= bcd_valid_d;
            refresh_cnt_q <= refresh_cnt_d;
            digit_idx_q   <= digit_idx_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign dsp.seg       = seg_q;
    assign dsp.an        = an_q;
    assign dsp.bcd       = bcd_q;
    assign dsp.bcd_valid = bcd_valid_q;

endmodule

// File: tb/tb_timer_display_driver.sv
// Randomized + directed bench for timer_display_driver against a decimal-arithmetic reference model.
// Latency: model predicts every output on every clock.
// Backpressure: not applicable.
module tb_timer_display_driver;

    localparam int RDIV = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    timer_display_driver_if dif ();

    timer_display_driver #(
        .REFRESH_DIV    (RDIV),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .dsp (dif)
    );

    int n_vec = 0;
    int n_err = 0;
    int t_cyc = 0;
    int dut_pulses = 0;

    // Reference model: value-level view of the driver
    int         m_last;
    bit         m_have;
    bit         m_busy;
    int         m_age;
    int         m_val;
    int         m_bcd;
    bit         m_valid;
    int         m_cyc;
    logic [6:0] m_seg;
    logic [2:0] m_an;

    logic [6:0] seg_hi [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, t_cyc, got, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_edge();
        int slot, h, t, o;
        if (rst) begin
            m_last = 0; m_have = 0; m_busy = 0; m_age = 0; m_val = 0;
            m_bcd = 0; m_valid = 0; m_cyc = 0;
            m_seg = 7'h7F; m_an = 3'b111;
        end else begin
            slot = (m_cyc / RDIV) % 3;
            h = m_bcd / 100; t = (m_bcd / 10) % 10; o = m_bcd % 10;
            m_seg = 7'h7F; m_an = 3'b111;
            if (dif.en && m_have) begin
                if (slot == 0) begin
                    m_an = 3'b110; m_seg = ~seg_hi[o];
                end else if (slot == 1 && m_bcd >= 10) begin
                    m_an = 3'b101; m_seg = ~seg_hi[t];
                end else if (slot == 2 && m_bcd >= 100) begin
                    m_an = 3'b011; m_seg = ~seg_hi[h];
                end
            end
            m_cyc++;
            m_valid = 0;
            if (m_busy) begin
                m_age++;
                if (m_age == 9) begin
                    m_bcd = m_val; m_valid = 1; m_have = 1; m_busy = 0;
                end
            end else if (dif.en && (!m_have || int'(dif.timer) != m_last)) begin
                m_last = int'(dif.timer); m_val = int'(dif.timer);
                m_busy = 1; m_age = 0;
            end
        end
    endtask

    // Apply inputs for one clock, then compare every output against the model
    task automatic step(input logic r, input logic [7:0] tm, input logic e);
        rst = r; dif.timer = tm; dif.en = e;
        @(posedge clk);
        model_edge();
        #1;
        t_cyc++;
        chk("an",  32'(dif.an),        32'(m_an));
        chk("seg", 32'(dif.seg),       32'(m_seg));
        chk("bcd", 32'(dif.bcd),       32'(to_bcd(m_bcd)));
        chk("vld", 32'(dif.bcd_valid), 32'(m_valid));
        if (dif.bcd_valid) dut_pulses++;
    endtask

    task automatic run(input int n, input logic r, input logic [7:0] tm, input logic e);
        for (int i = 0; i < n; i++) step(r, tm, e);
    endtask

    initial begin
        int p0;
        logic [7:0] rt;
        logic       re;
        rst = 1'b1; dif.timer = 8'd0; dif.en = 1'b0;

        // Reset holds everything dark
        run(3, 1'b1, 8'd42, 1'b1);
        chk("rst_bcd", 32'(dif.bcd), 32'h0);

        // Full-scale conversion and scan
        p0 = dut_pulses;
        run(40, 1'b0, 8'd255, 1'b1);
        chk("p255_cnt", 32'(dut_pulses - p0), 32'd1);
        chk("p255_val", 32'(dif.bcd), 32'h255);

        // Leading-zero blanking
        run(30, 1'b0, 8'd7, 1'b1);
        chk("p7_val", 32'(dif.bcd), 32'h007);
        run(30, 1'b0, 8'd0, 1'b1);
        chk("p0_val", 32'(dif.bcd), 32'h000);

        // Value change three cycles after capture
        p0 = dut_pulses;
        run(4, 1'b0, 8'd100, 1'b1);
        run(40, 1'b0, 8'd59, 1'b1);
        chk("chg_cnt", 32'(dut_pulses - p0), 32'd2);
        chk("chg_val", 32'(dif.bcd), 32'h059);

        // en gating: blank while low, resume without reconversion
        run(20, 1'b0, 8'd30, 1'b1);
        run(20, 1'b0, 8'd30, 1'b0);
        p0 = dut_pulses;
        run(20, 1'b0, 8'd30, 1'b1);
        chk("en_noconv", 32'(dut_pulses - p0), 32'd0);

        // Reset during the 4th shift cycle discards the partial result
        p0 = dut_pulses;
        run(4, 1'b0, 8'd200, 1'b1);
        run(2, 1'b1, 8'd200, 1'b1);
        chk("rst_mid_cnt", 32'(dut_pulses - p0), 32'd0);
        chk("rst_mid_bcd", 32'(dif.bcd), 32'h0);
        run(30, 1'b0, 8'd200, 1'b1);
        chk("rst_mid_val", 32'(dif.bcd), 32'h200);

        // Random phase: held values with occasional changes, en toggles, resets
        rt = 8'd123; re = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(14) == 0) begin
                case ($urandom_range(3))
                    0:       rt = 8'd0;
                    1:       rt = 8'd255;
                    default: rt = 8'($urandom_range(255));
                endcase
            end
            if ($urandom_range(39) == 0) re = ~re;
            step(($urandom_range(199) == 0) ? 1'b1 : 1'b0, rt, re);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
